// File: rtl/ex_pkg.sv
// Shared constants for the EX stage: ALU op encodings, multiply FSM
// states and bit positions inside the WB/M control bundles.
package ex_pkg;

    // ALU operation encodings carried in EXreg[2:0]
    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_SLL   = 3'b100;
    localparam logic [2:0] OP_SRL   = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    // EXreg bit selecting the immediate as ALU operand B
    localparam int EX_ALUSRC = 3;

    // WB bundle bit positions
    localparam int WB_REGWRITE = 0;
    localparam int WB_MEMTOREG = 1;

    // M bundle bit positions
    localparam int M_MEMREAD  = 0;
    localparam int M_MEMWRITE = 1;
    localparam int M_SPARE    = 2;

    // Multiplier sequencing states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } mul_state_t;

endpackage

// File: rtl/ex_stage_fwd_mul.sv
// Iterative shift-add multiplier. A start pulse in IDLE latches the
// operands; each following edge adds one partial product. 'last' marks
// the final iteration, during which 'product' already shows the
// complete low-WIDTH-bit result so the caller can register it on that edge.
module seq_mul16
    import ex_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int MUL_CYC = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             last,
    output logic [WIDTH-1:0] product
);

    localparam int CW = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    mul_state_t       state_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] addend_s;

    // Partial product for this iteration and the running sum including it
    always_comb begin
        addend_s = {WIDTH{1'b0}};
        if (mplier_r[0]) begin
            addend_s = mcand_r;
        end else begin
            addend_s = {WIDTH{1'b0}};
        end
        product = acc_r + addend_s;
        busy    = (state_r == ST_MUL);
        last    = (state_r == ST_MUL) && (count_r == CNT_LAST);
    end

    // Operand capture on start, then one shift-add step per edge until done
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            count_r  <= {CW{1'b0}};
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        mcand_r  <= a;
                        mplier_r <= b;
                        acc_r    <= {WIDTH{1'b0}};
                        count_r  <= {CW{1'b0}};
                        state_r  <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    acc_r    <= product;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    if (count_r == CNT_LAST) begin
                        count_r <= {CW{1'b0}};
                        state_r <= ST_IDLE;
                    end else begin
                        count_r <= count_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    count_r <= {CW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: rtl/ex_stage_fwd.sv
// EX pipeline stage: operand forwarding from EX/MEM and MEM/WB, ALU,
// compare-branch evaluation and the EX/MEM register. Multiplies run on
// the iterative multiplier and stall the upstream stages meanwhile.
module ex_stage_fwd
    import ex_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int RADDR   = 4,
    parameter int MUL_CYC = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             FPCreg,
    input  logic [1:0]       WBreg,
    input  logic [2:0]       Mreg,
    input  logic [3:0]       EXreg,
    input  logic [WIDTH-1:0] op1reg,
    input  logic [WIDTH-1:0] op2reg,
    input  logic [WIDTH-1:0] imm_valuereg,
    input  logic [RADDR-1:0] readReg1reg,
    input  logic [RADDR-1:0] readReg2reg,
    input  logic             exmem_wr,
    input  logic [RADDR-1:0] exmem_rd,
    input  logic [WIDTH-1:0] exmem_val,
    input  logic             memwb_wr,
    input  logic [RADDR-1:0] memwb_rd,
    input  logic [WIDTH-1:0] memwb_val,
    output logic             stall,
    output logic             flush,
    output logic [1:0]       WBout,
    output logic [2:0]       Mout,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] st_data,
    output logic [RADDR-1:0] rd_out,
    output logic             zero_out
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] fwd_a_s;
    logic [WIDTH-1:0] fwd_b_s;
    logic [WIDTH-1:0] alu_b_s;
    logic [WIDTH-1:0] alu_res_s;
    logic [WIDTH-1:0] br_diff_s;
    logic [2:0]       op_s;
    logic             mul_req_s;
    logic             mul_start_s;
    logic             mul_busy_s;
    logic             mul_last_s;
    logic [WIDTH-1:0] mul_product_s;

    logic [1:0]       nxt_wb_s;
    logic [2:0]       nxt_m_s;
    logic [WIDTH-1:0] nxt_alu_s;
    logic [WIDTH-1:0] nxt_st_s;
    logic [RADDR-1:0] nxt_rd_s;

    logic [1:0]       hold_wb_r;
    logic [2:0]       hold_m_r;
    logic [RADDR-1:0] hold_rd_r;
    logic [WIDTH-1:0] hold_st_r;

    // Youngest matching producer wins; r0 always reads as the ID/EX value
    function automatic logic [WIDTH-1:0] fwd_pick(
        input logic [RADDR-1:0] src,
        input logic [WIDTH-1:0] idex_val,
        input logic             xw,
        input logic [RADDR-1:0] xrd,
        input logic [WIDTH-1:0] xval,
        input logic             mw,
        input logic [RADDR-1:0] mrd,
        input logic [WIDTH-1:0] mval
    );
        logic [WIDTH-1:0] r;
        if (src == {RADDR{1'b0}}) begin
            r = idex_val;
        end else if (xw && (xrd == src)) begin
            r = xval;
        end else if (mw && (mrd == src)) begin
            r = mval;
        end else begin
            r = idex_val;
        end
        return r;
    endfunction

    // Forwarded operands, operand-B select and multiply request
    always_comb begin
        fwd_a_s   = fwd_pick(readReg1reg, op1reg, exmem_wr, exmem_rd, exmem_val,
                             memwb_wr, memwb_rd, memwb_val);
        fwd_b_s   = fwd_pick(readReg2reg, op2reg, exmem_wr, exmem_rd, exmem_val,
                             memwb_wr, memwb_rd, memwb_val);
        op_s      = EXreg[2:0];
        alu_b_s   = EXreg[EX_ALUSRC] ? imm_valuereg : fwd_b_s;
        br_diff_s = fwd_a_s - fwd_b_s;
        mul_req_s = (op_s == OP_MUL) && !FPCreg;
        mul_start_s = mul_req_s && !mul_busy_s;
    end

    // Single-cycle ALU; multiply results come from the sequential unit
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        case (op_s)
            OP_ADD:   alu_res_s = fwd_a_s + alu_b_s;
            OP_SUB:   alu_res_s = fwd_a_s - alu_b_s;
            OP_AND:   alu_res_s = fwd_a_s & alu_b_s;
            OP_OR:    alu_res_s = fwd_a_s | alu_b_s;
            OP_SLL:   alu_res_s = fwd_a_s << alu_b_s[SHW-1:0];
            OP_SRL:   alu_res_s = fwd_a_s >> alu_b_s[SHW-1:0];
            OP_MUL:   alu_res_s = {WIDTH{1'b0}};
            OP_PASSB: alu_res_s = alu_b_s;
            default:  alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    // Hazard outputs back to ID/EX and IF/ID, forced quiet during reset
    always_comb begin
        stall = 1'b0;
        flush = 1'b0;
        if (!reset) begin
            stall = 1'b0;
            flush = 1'b0;
        end else if (mul_busy_s) begin
            stall = !mul_last_s;
            flush = 1'b0;
        end else begin
            stall = mul_req_s;
            flush = FPCreg && (fwd_a_s == fwd_b_s);
        end
    end

    // Next EX/MEM contents: bubble unless a result is ready this edge
    always_comb begin
        nxt_wb_s  = 2'b00;
        nxt_m_s   = 3'b000;
        nxt_alu_s = {WIDTH{1'b0}};
        nxt_st_s  = {WIDTH{1'b0}};
        nxt_rd_s  = {RADDR{1'b0}};
        if (mul_busy_s) begin
            if (mul_last_s) begin
                nxt_wb_s  = hold_wb_r;
                nxt_m_s   = hold_m_r;
                nxt_alu_s = mul_product_s;
                nxt_st_s  = hold_st_r;
                nxt_rd_s  = hold_rd_r;
            end else begin
                nxt_wb_s  = 2'b00;
            end
        end else if (FPCreg) begin
            nxt_wb_s  = WBreg;
            nxt_m_s   = Mreg;
            nxt_alu_s = br_diff_s;
            nxt_st_s  = fwd_b_s;
            nxt_rd_s  = readReg1reg;
        end else if (mul_req_s) begin
            nxt_wb_s  = 2'b00;
        end else begin
            nxt_wb_s  = WBreg;
            nxt_m_s   = Mreg;
            nxt_alu_s = alu_res_s;
            nxt_st_s  = fwd_b_s;
            nxt_rd_s  = readReg1reg;
        end
    end

    // EX/MEM register plus the control held across a multiply
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            WBout     <= 2'b00;
            Mout      <= 3'b000;
            alu_out   <= {WIDTH{1'b0}};
            st_data   <= {WIDTH{1'b0}};
            rd_out    <= {RADDR{1'b0}};
            zero_out  <= 1'b0;
            hold_wb_r <= 2'b00;
            hold_m_r  <= 3'b000;
            hold_rd_r <= {RADDR{1'b0}};
            hold_st_r <= {WIDTH{1'b0}};
        end else begin
            WBout    <= nxt_wb_s;
            Mout     <= nxt_m_s;
            alu_out  <= nxt_alu_s;
            st_data  <= nxt_st_s;
            rd_out   <= nxt_rd_s;
            zero_out <= (nxt_alu_s == {WIDTH{1'b0}}) && (nxt_wb_s != 2'b00 || nxt_m_s != 3'b000
                        || nxt_rd_s != {RADDR{1'b0}} || !(mul_busy_s || mul_req_s)
                        || (mul_busy_s && mul_last_s));
            if (mul_start_s) begin
                hold_wb_r <= WBreg;
                hold_m_r  <= Mreg;
                hold_rd_r <= readReg1reg;
                hold_st_r <= fwd_b_s;
            end
        end
    end

    seq_mul16 #(
        .WIDTH   (WIDTH),
        .MUL_CYC (MUL_CYC)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start_s),
        .a       (fwd_a_s),
        .b       (alu_b_s),
        .busy    (mul_busy_s),
        .last    (mul_last_s),
        .product (mul_product_s)
    );

endmodule

// File: tb/tb_ex_stage_fwd.sv
// Directed plus randomized bench for ex_stage_fwd. Expected values come
// from a behavioural model of the stage: forwarding priority, plain
// arithmetic for each op, and cycle-level multiply timing.
module tb_ex_stage_fwd;

    logic        clk;
    logic        reset;
    logic        FPCreg;
    logic [1:0]  WBreg;
    logic [2:0]  Mreg;
    logic [3:0]  EXreg;
    logic [15:0] op1reg, op2reg, imm_valuereg;
    logic [3:0]  readReg1reg, readReg2reg;
    logic        exmem_wr, memwb_wr;
    logic [3:0]  exmem_rd, memwb_rd;
    logic [15:0] exmem_val, memwb_val;
    logic        stall, flush, zero_out;
    logic [1:0]  WBout;
    logic [2:0]  Mout;
    logic [15:0] alu_out, st_data;
    logic [3:0]  rd_out;

    int tests = 0;
    int fails = 0;

    ex_stage_fwd dut (
        .clk(clk), .reset(reset), .FPCreg(FPCreg), .WBreg(WBreg), .Mreg(Mreg),
        .EXreg(EXreg), .op1reg(op1reg), .op2reg(op2reg), .imm_valuereg(imm_valuereg),
        .readReg1reg(readReg1reg), .readReg2reg(readReg2reg),
        .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_val(exmem_val),
        .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_val(memwb_val),
        .stall(stall), .flush(flush), .WBout(WBout), .Mout(Mout),
        .alu_out(alu_out), .st_data(st_data), .rd_out(rd_out), .zero_out(zero_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference forwarding: newest producer first, r0 never forwarded
    function automatic logic [15:0] fwd_ref(input logic [3:0] src, input logic [15:0] own);
        if (src != 4'd0 && exmem_wr && exmem_rd == src) return exmem_val;
        if (src != 4'd0 && memwb_wr && memwb_rd == src) return memwb_val;
        return own;
    endfunction

    // Reference ALU using 32-bit arithmetic truncated to 16 bits
    function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] wa, wb, x;
        int sh;
        wa = {16'd0, a};
        wb = {16'd0, b};
        sh = int'(b % 16'd16);
        case (op)
            3'd0: x = wa + wb;
            3'd1: x = wa - wb;
            3'd2: x = wa & wb;
            3'd3: x = wa | wb;
            3'd4: x = wa << sh;
            3'd5: x = wa >> sh;
            3'd6: x = wa * wb;
            default: x = wb;
        endcase
        return x[15:0];
    endfunction

    task automatic clear_fwd();
        exmem_wr = 1'b0; exmem_rd = 4'd0; exmem_val = 16'd0;
        memwb_wr = 1'b0; memwb_rd = 4'd0; memwb_val = 16'd0;
    endtask

    task automatic set_instr(input logic fpc, input logic [1:0] wb, input logic [2:0] m,
                             input logic [3:0] ex, input logic [15:0] o1, input logic [15:0] o2,
                             input logic [15:0] imm, input logic [3:0] r1, input logic [3:0] r2);
        FPCreg = fpc; WBreg = wb; Mreg = m; EXreg = ex;
        op1reg = o1; op2reg = o2; imm_valuereg = imm;
        readReg1reg = r1; readReg2reg = r2;
    endtask

    task automatic scramble();
        FPCreg = 1'($urandom_range(0, 1));
        WBreg = 2'($urandom); Mreg = 3'($urandom); EXreg = 4'($urandom);
        op1reg = 16'($urandom); op2reg = op1reg; imm_valuereg = 16'($urandom);
        readReg1reg = 4'($urandom_range(0, 3)); readReg2reg = 4'($urandom_range(0, 3));
        exmem_wr = 1'($urandom); exmem_rd = 4'($urandom_range(0, 3)); exmem_val = 16'($urandom);
        memwb_wr = 1'($urandom); memwb_rd = 4'($urandom_range(0, 3)); memwb_val = 16'($urandom);
    endtask

    // Present the currently driven instruction and check it to completion
    task automatic issue(input string tag, output int edges);
        logic [15:0] a, fb, b, res;
        logic [2:0]  op;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  rd;
        logic        exp_stall, exp_flush, fin, done;
        int          stall_cnt;
        #1;
        a  = fwd_ref(readReg1reg, op1reg);
        fb = fwd_ref(readReg2reg, op2reg);
        b  = EXreg[3] ? imm_valuereg : fb;
        op = EXreg[2:0];
        wb = WBreg; m = Mreg; rd = readReg1reg;
        exp_stall = !FPCreg && (op == 3'd6);
        exp_flush = FPCreg && (a == fb);
        chk({tag, "_stall"}, 16'(stall), 16'(exp_stall));
        chk({tag, "_flush"}, 16'(flush), 16'(exp_flush));
        edges = 0;
        if (!exp_stall) begin
            res = FPCreg ? (a - fb) : alu_ref(op, a, b);
            @(posedge clk); #1; edges = 1;
            chk({tag, "_alu"},  alu_out, res);
            chk({tag, "_zero"}, 16'(zero_out), 16'(res == 16'd0));
            chk({tag, "_wb"},   16'(WBout), 16'(wb));
            chk({tag, "_m"},    16'(Mout), 16'(m));
            chk({tag, "_rd"},   16'(rd_out), 16'(rd));
            chk({tag, "_st"},   st_data, fb);
        end else begin
            res = alu_ref(3'd6, a, b);
            stall_cnt = 1; done = 1'b0;
            @(posedge clk); #1; edges = 1;
            chk({tag, "_bub_wb"},  16'(WBout), 16'd0);
            chk({tag, "_bub_alu"}, alu_out, 16'd0);
            for (int i = 0; i < 24 && !done; i++) begin
                scramble(); #1;
                chk({tag, "_mul_flush"}, 16'(flush), 16'd0);
                fin = !stall;
                if (stall) stall_cnt++;
                @(posedge clk); #1; edges++;
                if (fin) begin
                    done = 1'b1;
                    chk({tag, "_prod"},  alu_out, res);
                    chk({tag, "_pwb"},   16'(WBout), 16'(wb));
                    chk({tag, "_pm"},    16'(Mout), 16'(m));
                    chk({tag, "_prd"},   16'(rd_out), 16'(rd));
                    chk({tag, "_pst"},   st_data, fb);
                    chk({tag, "_pzero"}, 16'(zero_out), 16'(res == 16'd0));
                end else begin
                    chk({tag, "_bub_wb"},  16'(WBout), 16'd0);
                    chk({tag, "_bub_alu"}, alu_out, 16'd0);
                end
            end
            chk({tag, "_mul_done"}, 16'(done), 16'd1);
            chk({tag, "_stall_cycles"}, 16'(stall_cnt), 16'd16);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_alu"},   alu_out, 16'd0);
        chk({tag, "_wb"},    16'(WBout), 16'd0);
        chk({tag, "_m"},     16'(Mout), 16'd0);
        chk({tag, "_rd"},    16'(rd_out), 16'd0);
        chk({tag, "_st"},    st_data, 16'd0);
        chk({tag, "_zero"},  16'(zero_out), 16'd0);
        chk({tag, "_stall"}, 16'(stall), 16'd0);
        chk({tag, "_flush"}, 16'(flush), 16'd0);
    endtask

    initial begin
        int e, e1, e2;
        logic [3:0] ex;

        // Reset with a would-flush compare presented, then a would-stall mul
        reset = 1'b0;
        clear_fwd();
        set_instr(1'b1, 2'b01, 3'b000, 4'b0000, 16'h1234, 16'h1234, 16'h0000, 4'h1, 4'h2);
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("rst_fpc");
        set_instr(1'b0, 2'b01, 3'b000, 4'b0110, 16'h0003, 16'h0005, 16'h0000, 4'h1, 4'h2);
        #1;
        chk_zero_outputs("rst_mul");
        @(negedge clk);
        reset = 1'b1;

        // 1: add with immediate
        set_instr(1'b0, 2'b01, 3'b000, 4'b1000, 16'h0005, 16'h0000, 16'h0003, 4'h1, 4'h2);
        issue("t1", e);
        chk("t1_lit", alu_out, 16'h0008);
        chk("t1_zero_lit", 16'(zero_out), 16'd0);

        // 2: forwarding priority and r0 exclusion
        exmem_wr = 1'b1; exmem_rd = 4'h3; exmem_val = 16'h00AA;
        memwb_wr = 1'b1; memwb_rd = 4'h3; memwb_val = 16'h0055;
        set_instr(1'b0, 2'b01, 3'b000, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 4'h3, 4'h0);
        issue("t2a", e);
        chk("t2a_lit", alu_out, 16'h00AA);
        exmem_wr = 1'b1; exmem_rd = 4'h3; exmem_val = 16'h00AA;
        memwb_wr = 1'b1; memwb_rd = 4'h3; memwb_val = 16'h0055;
        set_instr(1'b0, 2'b01, 3'b000, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 4'h0, 4'h0);
        issue("t2b", e);
        chk("t2b_lit", alu_out, 16'h0000);
        exmem_wr = 1'b0; memwb_wr = 1'b1; memwb_rd = 4'h3; memwb_val = 16'h0055;
        set_instr(1'b0, 2'b01, 3'b000, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 4'h3, 4'h0);
        issue("t2c", e);
        chk("t2c_lit", alu_out, 16'h0055);

        // 3: multiply 3*5
        clear_fwd();
        set_instr(1'b0, 2'b01, 3'b000, 4'b0110, 16'h0003, 16'h0005, 16'h0000, 4'h4, 4'h5);
        issue("t3", e);
        chk("t3_lit", alu_out, 16'h000F);
        chk("t3_edges", 16'(e), 16'd17);

        // 4: compare-branch equal and not equal
        clear_fwd();
        set_instr(1'b1, 2'b00, 3'b000, 4'b0110, 16'hBBBB, 16'hBBBB, 16'h0000, 4'h6, 4'h7);
        #1;
        chk("t4_flush_lit", 16'(flush), 16'd1);
        issue("t4a", e);
        chk("t4a_lit", alu_out, 16'h0000);
        chk("t4a_zero_lit", 16'(zero_out), 16'd1);
        set_instr(1'b1, 2'b00, 3'b000, 4'b0000, 16'hBBBB, 16'hBBBA, 16'h0000, 4'h6, 4'h7);
        #1;
        chk("t4b_flush_lit", 16'(flush), 16'd0);
        issue("t4b", e);
        chk("t4b_lit", alu_out, 16'h0001);

        // 5: reset in the middle of a multiply
        clear_fwd();
        set_instr(1'b0, 2'b01, 3'b010, 4'b0110, 16'h1111, 16'h1111, 16'h0000, 4'h5, 4'h6);
        #1;
        chk("t5_stall0", 16'(stall), 16'd1);
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk_zero_outputs("t5_abort");
        @(negedge clk);
        reset = 1'b1;
        set_instr(1'b0, 2'b01, 3'b000, 4'b1000, 16'h0001, 16'h0000, 16'h0001, 4'h1, 4'h2);
        issue("t5_add", e);
        chk("t5_lit", alu_out, 16'h0002);

        // 6: back-to-back multiplies
        clear_fwd();
        set_instr(1'b0, 2'b01, 3'b000, 4'b0110, 16'h0002, 16'h0003, 16'h0000, 4'h8, 4'h9);
        issue("t6a", e1);
        chk("t6a_lit", alu_out, 16'h0006);
        clear_fwd();
        set_instr(1'b0, 2'b01, 3'b000, 4'b0110, 16'h0004, 16'h0005, 16'h0000, 4'h9, 4'hA);
        issue("t6b", e2);
        chk("t6b_lit", alu_out, 16'h0014);
        chk("t6_edges", 16'(e1 + e2), 16'd34);

        // Randomized instruction stream against the model
        for (int n = 0; n < 60; n++) begin
            ex = 4'($urandom);
            if (ex[2:0] == 3'b110) ex[3] = 1'b0;
            set_instr(($urandom_range(0, 5) == 0), 2'($urandom), 3'($urandom), ex,
                      16'($urandom), 16'($urandom), 16'($urandom),
                      4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) op2reg = op1reg;
            exmem_wr = 1'($urandom); exmem_rd = 4'($urandom_range(0, 3)); exmem_val = 16'($urandom);
            memwb_wr = 1'($urandom); memwb_rd = 4'($urandom_range(0, 3)); memwb_val = 16'($urandom);
            issue("rnd", e);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
